peak_scan_ctrl: RTL and testbench
=================================

PEAK_SCAN_CTRL -- requirements
Module: peak_scan_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: sample and threshold width (unsigned).
REQ-002 Parameter ADDR_W, default 16: sample-memory address and length width.
REQ-003 ACLK  in  1  single clock; all logic on rising edge.
REQ-004 ARESETN  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse from the AXI4-Lite register file; begins a scan.
REQ-006 abort  in  1  one-cycle pulse; cancels an active scan.
REQ-007 scan_len  in  ADDR_W  number of samples to scan; sampled on accepted start.
REQ-008 threshold  in  DATA_W  count threshold; sampled on accepted start.
REQ-009 mem_rd_en  out  1  sample-memory read strobe.
REQ-010 mem_addr  out  ADDR_W  sample-memory word address.
REQ-011 mem_rdata  in  DATA_W  read data, valid exactly one cycle after mem_rd_en.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 done  out  1  one-cycle pulse on scan completion.
REQ-014 peak_val  out  DATA_W  largest sample of the last completed scan.
REQ-015 peak_idx  out  ADDR_W  index of peak_val.
REQ-016 over_cnt  out  ADDR_W  samples strictly greater than threshold in the last completed scan.
REQ-017 irq  out  1  sticky completion interrupt.
REQ-018 irq_clr  in  1  one-cycle pulse; clears irq.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE: start with scan_len>0 goes to RUN, latches scan_len and threshold, clears working max/idx/count; start with scan_len=0 goes directly to DONE.
REQ-021 RUN: mem_rd_en=1, with mem_addr = 0,1,...,scan_len-1 on consecutive cycles; after address scan_len-1 goes to DRAIN.
REQ-022 DRAIN: mem_rd_en=0; processes the final returned sample; goes to DONE.
REQ-023 DONE: done=1 for one cycle; copies working registers to peak_val/peak_idx/over_cnt; goes to IDLE.
REQ-024 Latency: if start is accepted in cycle 0, done is asserted in cycle scan_len+2; for scan_len=0, done is asserted in cycle 1 with no memory reads.
REQ-025 Each returned sample is compared in the cycle it is valid; the first sample always initialises max; a later sample replaces max only if strictly greater, so ties keep the lowest index.
REQ-026 The sample count increments when a sample is strictly greater than threshold; the count cannot overflow because it is bounded by scan_len.
REQ-027 For scan_len=0, results are peak_val=0, peak_idx=0, over_cnt=0.
REQ-028 start while busy is ignored.
REQ-029 abort in RUN or DRAIN forces IDLE on the next edge with no done and no result update; a read already in flight is discarded.
REQ-030 Simultaneous start and abort in IDLE: start wins.
REQ-031 abort in DONE is ignored, and the scan completes.
REQ-032 Result outputs change only in DONE and hold between scans.

Reset
REQ-033 While ARESETN=0, the FSM is IDLE and mem_rd_en, mem_addr, busy, done, peak_val, peak_idx, over_cnt, and irq are all 0.
REQ-034 Reset assertion mid-scan takes effect immediately (asynchronously); deassertion is synchronised to ACLK, and the first start is accepted on the first edge after deassertion.

Configuration
REQ-035 Macro PEAK_SCAN_IRQ_EN defined: irq is set in the cycle after DONE and is cleared by irq_clr; a simultaneous set and clear leaves irq set.
REQ-036 Macro PEAK_SCAN_IRQ_EN undefined: irq is tied to 0 and irq_clr is ignored; all other behaviour is unchanged.

Verification
REQ-037 Memory holds {5,9,3,9,2}, scan_len=5, threshold=4, start -> done in cycle 7, peak_val=9, peak_idx=1, over_cnt=3, and exactly 5 reads at addresses 0..4.
REQ-038 scan_len=0 with start -> done in cycle 1, all results 0, mem_rd_en never asserted.
REQ-039 scan_len=100 of descending data 100..1, abort in cycle 50 -> busy drops in cycle 51, no done, and results keep the previous scan's values; a subsequent start runs a full, correct scan.
REQ-040 start pulsed again in cycle 3 of a scan_len=8 scan -> ignored; single done in cycle 10.
REQ-041 With PEAK_SCAN_IRQ_EN: irq rises after done, and irq_clr asserted in the same cycle as the next scan's set leaves irq=1; without the macro, irq stays 0 throughout.
REQ-042 ARESETN pulled low in mid-RUN -> all outputs are 0 immediately, with no done; scanning resumes correctly after release.

Source files
------------

// File: rtl/peak_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : peak_scan_ctrl
// Brief    : Scans scan_len words of sample memory, reporting the peak value,
//            its index and the count of samples above a threshold.
//            Optional completion interrupt: define PEAK_SCAN_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module peak_scan_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] scan_len,
    input  logic [DATA_W-1:0] threshold,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] peak_val,
    output logic [ADDR_W-1:0] peak_idx,
    output logic [ADDR_W-1:0] over_cnt,
    output logic              irq,
    input  logic              irq_clr
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_len;
    logic [DATA_W-1:0] r_thr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_idx;
    logic              r_have;
    logic [DATA_W-1:0] r_max;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_peak_val;
    logic [ADDR_W-1:0] r_peak_idx;
    logic [ADDR_W-1:0] r_over_cnt;

    logic              w_take;
    logic              w_over;
    logic              w_last;
    logic [DATA_W-1:0] w_max_nxt;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    // The first sample always seeds the max; later ones must be strictly larger
    assign w_take    = r_pend && (!r_have || (mem_rdata > r_max));
    assign w_over    = r_pend && (mem_rdata > r_thr);
    assign w_max_nxt = w_take ? mem_rdata : r_max;
    assign w_idx_nxt = w_take ? r_pend_idx : r_idx;
    assign w_cnt_nxt = w_over ? (r_cnt + ADDR_W'(1)) : r_cnt;
    assign w_last    = (r_addr == (r_len - ADDR_W'(1)));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state    <= c_IDLE;
            r_len      <= '0;
            r_thr      <= '0;
            r_addr     <= '0;
            r_pend     <= 1'b0;
            r_pend_idx <= '0;
            r_have     <= 1'b0;
            r_max      <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_peak_val <= '0;
            r_peak_idx <= '0;
            r_over_cnt <= '0;
        end else begin
            // A read issued in an aborted cycle is never accumulated
            r_pend     <= (r_state == c_RUN) && !abort;
            r_pend_idx <= r_addr;

            if ((r_state == c_IDLE) && start) begin
                r_have <= 1'b0;
                r_max  <= '0;
                r_idx  <= '0;
                r_cnt  <= '0;
            end else if (r_pend) begin
                r_have <= 1'b1;
                r_max  <= w_max_nxt;
                r_idx  <= w_idx_nxt;
                r_cnt  <= w_cnt_nxt;
            end

            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (scan_len == '0) begin
                            r_state    <= c_DONE;
                            r_peak_val <= '0;
                            r_peak_idx <= '0;
                            r_over_cnt <= '0;
                        end else begin
                            r_state <= c_RUN;
                            r_len   <= scan_len;
                            r_thr   <= threshold;
                            r_addr  <= '0;
                        end
                    end
                end
                c_RUN: begin
                    if (abort) begin
                        r_state <= c_IDLE;
                        r_addr  <= '0;
                    end else if (w_last) begin
                        r_state <= c_DRAIN;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                c_DRAIN: begin
                    if (abort) begin
                        r_state <= c_IDLE;
                        r_addr  <= '0;
                    end else begin
                        // Results are published together with the done pulse
                        r_state    <= c_DONE;
                        r_peak_val <= w_max_nxt;
                        r_peak_idx <= w_idx_nxt;
                        r_over_cnt <= w_cnt_nxt;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

`ifdef PEAK_SCAN_IRQ_EN
    logic r_irq;

    // Set has priority over a coincident clear
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_irq <= 1'b0;
        end else if (r_state == c_DONE) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`else
    logic w_irq_clr_unused;

    assign w_irq_clr_unused = irq_clr;
    assign irq              = 1'b0;
`endif

    assign mem_rd_en = (r_state == c_RUN);
    assign mem_addr  = r_addr;
    assign busy      = (r_state != c_IDLE);
    assign done      = (r_state == c_DONE);
    assign peak_val  = r_peak_val;
    assign peak_idx  = r_peak_idx;
    assign over_cnt  = r_over_cnt;

endmodule
`default_nettype wire

// File: tb/tb_peak_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_peak_scan_ctrl
// Brief    : Self-checking bench for peak_scan_ctrl with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_peak_scan_ctrl;

    localparam int DW = 32;
    localparam int AW = 16;

    typedef struct packed {
        logic [DW-1:0] pv;
        logic [AW-1:0] pi;
        logic [AW-1:0] oc;
    } res_t;

    logic          ACLK      = 1'b0;
    logic          ARESETN   = 1'b0;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic          irq_clr   = 1'b0;
    logic [AW-1:0] scan_len  = '0;
    logic [DW-1:0] threshold = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic          busy;
    logic          done;
    logic [DW-1:0] peak_val;
    logic [AW-1:0] peak_idx;
    logic [AW-1:0] over_cnt;
    logic          irq;

    logic [DW-1:0] mem [0:127];
    res_t          exp_q [$];
    logic [AW-1:0] rd_log [$];
    int            total = 0;
    int            bad   = 0;

    peak_scan_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .start     (start),
        .abort     (abort),
        .scan_len  (scan_len),
        .threshold (threshold),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .peak_val  (peak_val),
        .peak_idx  (peak_idx),
        .over_cnt  (over_cnt),
        .irq       (irq),
        .irq_clr   (irq_clr)
    );

    always #5 ACLK = ~ACLK;

    // Sample memory: one-cycle read latency
    always @(posedge ACLK) mem_rdata <= mem[mem_addr[6:0]];

    always @(negedge ACLK) begin
        if (ARESETN && mem_rd_en) rd_log.push_back(mem_addr);
    end

    // Scoreboard: every done pulse must match the oldest expected result
    always @(negedge ACLK) begin
        if (ARESETN && done) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_done: got done=1, required no done");
            end else begin
                res_t e;
                e = exp_q.pop_front();
                if ({peak_val, peak_idx, over_cnt} !== {e.pv, e.pi, e.oc}) begin
                    bad++;
                    $display("FAIL sb_result: got val=%0d idx=%0d cnt=%0d, required val=%0d idx=%0d cnt=%0d",
                             peak_val, peak_idx, over_cnt, e.pv, e.pi, e.oc);
                end
            end
        end
    end

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    function automatic res_t model(int len, logic [DW-1:0] thr);
        res_t r;
        r = '0;
        for (int i = 0; i < len; i++) begin
            if (i == 0 || mem[i] > r.pv) begin
                r.pv = mem[i];
                r.pi = AW'(i);
            end
            if (mem[i] > thr) r.oc = r.oc + AW'(1);
        end
        return r;
    endfunction

    // Pulses start in cycle 0; returns in cycle 1
    task automatic launch(int len, logic [DW-1:0] thr, bit push);
        scan_len  = AW'(len);
        threshold = thr;
        start     = 1'b1;
        rd_log.delete();
        if (push) exp_q.push_back(model(len, thr));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 1000) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset;
        repeat (3) tick();
        total++;
        if ({mem_rd_en, busy, done, irq} !== 4'b0 || mem_addr !== '0 ||
            peak_val !== '0 || peak_idx !== '0 || over_cnt !== '0) begin
            bad++;
            $display("FAIL reset_state: got rd=%b busy=%b done=%b irq=%b addr=%0d val=%0d idx=%0d cnt=%0d, required all 0",
                     mem_rd_en, busy, done, irq, mem_addr, peak_val, peak_idx, over_cnt);
        end
        ARESETN = 1'b1;
    endtask

    task automatic test_basic;
        int cyc;
        mem[0] = 5; mem[1] = 9; mem[2] = 3; mem[3] = 9; mem[4] = 2;
        launch(5, 4, 1);
        total++;
        if (busy !== 1'b1 || mem_rd_en !== 1'b1 || mem_addr !== '0) begin
            bad++;
            $display("FAIL basic_first_read: got busy=%b rd=%b addr=%0d, required 1 1 0", busy, mem_rd_en, mem_addr);
        end
        wait_done(cyc);
        total++;
        if (cyc !== 7) begin
            bad++;
            $display("FAIL basic_latency: got done in cycle %0d, required 7", cyc);
        end
        total++;
        if (peak_val !== 9 || peak_idx !== 1 || over_cnt !== 3) begin
            bad++;
            $display("FAIL basic_values: got %0d/%0d/%0d, required 9/1/3", peak_val, peak_idx, over_cnt);
        end
        total++;
        if (rd_log.size() != 5) begin
            bad++;
            $display("FAIL basic_read_count: got %0d, required 5", rd_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (rd_log[i] !== AW'(i)) begin
                    bad++;
                    $display("FAIL basic_read_addr: got %0d, required %0d", rd_log[i], i);
                end
            end
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_pulse: got done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_zero_len;
        int cyc;
        launch(0, 0, 1);
        wait_done(cyc);
        total++;
        if (cyc !== 1) begin
            bad++;
            $display("FAIL zero_latency: got done in cycle %0d, required 1", cyc);
        end
        total++;
        if (peak_val !== '0 || peak_idx !== '0 || over_cnt !== '0) begin
            bad++;
            $display("FAIL zero_values: got %0d/%0d/%0d, required 0/0/0", peak_val, peak_idx, over_cnt);
        end
        tick();
        total++;
        if (rd_log.size() != 0) begin
            bad++;
            $display("FAIL zero_reads: got %0d reads, required 0", rd_log.size());
        end
    endtask

    task automatic test_abort;
        int   cyc;
        bit   saw;
        res_t prev;
        for (int i = 0; i < 100; i++) mem[i] = DW'(100 - i);
        prev = model(3, 50);
        launch(3, 50, 1);
        wait_done(cyc);
        tick();
        launch(100, 0, 0);
        repeat (49) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_busy: got busy=%b in cycle 51, required 0", busy);
        end
        saw = 1'b0;
        repeat (20) begin
            if (done === 1'b1) saw = 1'b1;
            tick();
        end
        total++;
        if (saw) begin
            bad++;
            $display("FAIL abort_no_done: got done after abort, required none");
        end
        total++;
        if ({peak_val, peak_idx, over_cnt} !== {prev.pv, prev.pi, prev.oc}) begin
            bad++;
            $display("FAIL abort_hold: got %0d/%0d/%0d, required %0d/%0d/%0d",
                     peak_val, peak_idx, over_cnt, prev.pv, prev.pi, prev.oc);
        end
        launch(100, 40, 1);
        wait_done(cyc);
        total++;
        if (cyc !== 102 || rd_log.size() != 100) begin
            bad++;
            $display("FAIL abort_rescan: got cycle %0d reads %0d, required 102 100", cyc, rd_log.size());
        end
        tick();
    endtask

    task automatic test_restart_ignored;
        int cyc;
        int dcount;
        mem[0] = 3; mem[1] = 7; mem[2] = 7; mem[3] = 1;
        mem[4] = 7; mem[5] = 0; mem[6] = 2; mem[7] = 6;
        launch(8, 5, 1);
        repeat (2) tick();
        start    = 1'b1;
        scan_len = 2;
        tick();
        start = 1'b0;
        cyc = 4;
        while (done !== 1'b1 && cyc < 1000) begin
            tick();
            cyc++;
        end
        total++;
        if (cyc !== 10 || rd_log.size() != 8) begin
            bad++;
            $display("FAIL restart_latency: got cycle %0d reads %0d, required 10 8", cyc, rd_log.size());
        end
        dcount = 0;
        repeat (15) begin
            tick();
            if (done === 1'b1) dcount++;
        end
        total++;
        if (dcount != 0) begin
            bad++;
            $display("FAIL restart_single_done: got %0d extra done, required 0", dcount);
        end
    endtask

    task automatic test_start_abort_idle;
        int   cyc;
        res_t e;
        e     = model(5, 4);
        abort = 1'b1;
        launch(5, 4, 1);
        abort = 1'b0;
        wait_done(cyc);
        total++;
        if (cyc !== 7) begin
            bad++;
            $display("FAIL start_wins: got done in cycle %0d, required 7", cyc);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || {peak_val, peak_idx, over_cnt} !== {e.pv, e.pi, e.oc}) begin
            bad++;
            $display("FAIL abort_in_done: got busy=%b %0d/%0d/%0d, required 0 %0d/%0d/%0d",
                     busy, peak_val, peak_idx, over_cnt, e.pv, e.pi, e.oc);
        end
    endtask

    task automatic test_irq;
        int cyc;
`ifdef PEAK_SCAN_IRQ_EN
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_clear_initial: got %b, required 0", irq);
        end
        launch(3, 0, 1);
        wait_done(cyc);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_at_done: got %b, required 0", irq);
        end
        tick();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_set: got %b, required 1", irq);
        end
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_clr: got %b, required 0", irq);
        end
        launch(3, 0, 1);
        wait_done(cyc);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_set_wins: got %b, required 1", irq);
        end
`else
        launch(3, 0, 1);
        wait_done(cyc);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_disabled: got %b, required 0", irq);
        end
`endif
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        launch(20, 0, 0);
        repeat (4) tick();
        #2;
        ARESETN = 1'b0;
        #1;
        total++;
        if ({mem_rd_en, busy, done, irq} !== 4'b0 || mem_addr !== '0 ||
            peak_val !== '0 || peak_idx !== '0 || over_cnt !== '0) begin
            bad++;
            $display("FAIL reset_mid_run: got rd=%b busy=%b done=%b irq=%b addr=%0d val=%0d idx=%0d cnt=%0d, required all 0",
                     mem_rd_en, busy, done, irq, mem_addr, peak_val, peak_idx, over_cnt);
        end
        tick();
        ARESETN = 1'b1;
        launch(20, 50, 1);
        wait_done(cyc);
        total++;
        if (cyc !== 22 || rd_log.size() != 20) begin
            bad++;
            $display("FAIL reset_rescan: got cycle %0d reads %0d, required 22 20", cyc, rd_log.size());
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_zero_len();
        tick();
        test_abort();
        test_restart_ignored();
        test_start_abort_idle();
        tick();
        test_irq();
        tick();
        test_reset_mid_run();
        repeat (3) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending results, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
